// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath/cache types
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache, one word per frame
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS          = 16,
  parameter bit PC_RESET_SAFE = 1'b1
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  localparam int IB = $clog2(SETS);
  localparam int TW = WORD_W - IB - 2;

  typedef struct packed {
    logic [TW-1:0] tag;
    word_t         data;
  } icache_frame_t;

  icache_state_t state;
  word_t         miss_addr;
  logic [SETS-1:0] valid;
  icache_frame_t   frames [SETS];

  logic [IB-1:0] idx;
  logic [TW-1:0] tag;
  logic [IB-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  icache_frame_t rd;
  logic          hit;
  logic          fill_done;
  logic          unused_ok;

  assign idx      = imemaddr[IB+1:2];
  assign tag      = imemaddr[WORD_W-1:IB+2];
  assign fill_idx = miss_addr[IB+1:2];
  assign fill_tag = miss_addr[WORD_W-1:IB+2];
  assign unused_ok = ^{imemaddr[1:0], miss_addr[1:0]};

  assign rd        = frames[idx];
  assign hit       = imemREN && valid[idx] && (rd.tag == tag);
  assign fill_done = (state == FILL) && !iwait;

  // Hits are only reported from IDLE, so a redirect during a fill waits for the fill.
  assign ihit     = (state == IDLE) && hit;
  assign imemload = (ihit || !PC_RESET_SAFE) ? rd.data : '0;
  assign iREN     = (state == FILL);
  assign iaddr    = miss_addr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !hit) begin
            miss_addr <= {imemaddr[WORD_W-1:2], 2'b00};
            state     <= FILL;
          end
        end
        FILL: begin
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data need no reset; valid alone decides whether a frame is usable.
  always_ff @(posedge CLK) begin
    if (nRST && fill_done) begin
      frames[fill_idx] <= '{tag: fill_tag, data: iload};
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed scoreboard bench for icache
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  int checks = 0;
  int passes = 0;
  word_t exp_q[$];

  icache #(.SETS(16), .PC_RESET_SAFE(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic word_t mem_of(input word_t a);
    word_t w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0) return 32'h2001_0005;
    return {w[15:0] ^ 16'hA5C3, w[17:2] ^ 16'h5A00};
  endfunction

  task automatic chk(input string name, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  task automatic pop_chk(input string name);
    word_t e;
    if (exp_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_data"}, imemload, e);
    end
  endtask

  task automatic fetch(input word_t addr, input bit miss, input int waits, input string name);
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    exp_q.push_back(mem_of(addr));
    @(negedge CLK);
    if (!miss) begin
      chk({name, "_hit"}, {31'd0, ihit}, 32'd1);
      chk({name, "_iren"}, {31'd0, iREN}, 32'd0);
      pop_chk(name);
    end else begin
      chk({name, "_miss"}, {31'd0, ihit}, 32'd0);
      for (int w = 0; w <= waits; w++) begin
        @(posedge CLK); #1;
        iwait = (w == waits) ? 1'b0 : 1'b1;
        iload = (w == waits) ? mem_of(addr) : $urandom;
        @(negedge CLK);
        chk({name, "_fill_iren"}, {31'd0, iREN}, 32'd1);
        chk({name, "_fill_iaddr"}, iaddr, {addr[31:2], 2'b00});
        chk({name, "_fill_nohit"}, {31'd0, ihit}, 32'd0);
      end
      @(posedge CLK); #1;
      iwait = 1'b1; iload = $urandom;
      @(negedge CLK);
      chk({name, "_after_hit"}, {31'd0, ihit}, 32'd1);
      chk({name, "_after_iren"}, {31'd0, iREN}, 32'd0);
      pop_chk(name);
    end
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    #12;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    fetch(32'h0000_0000, 1'b1, 3, "cold0");
    fetch(32'h0000_0000, 1'b0, 0, "rehit0");
    fetch(32'h0000_0003, 1'b0, 0, "byteoff");

    // cached address with imemREN low must not hit or start a fill
    @(posedge CLK); #1;
    imemREN = 1'b0; imemaddr = 32'h0;
    @(negedge CLK);
    chk("noren_ihit", {31'd0, ihit}, 32'd0);
    chk("noren_imemload", imemload, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("noren_iren", {31'd0, iREN}, 32'd0);

    fetch(32'h0000_0004, 1'b1, 1, "confA");
    fetch(32'h0000_0044, 1'b1, 0, "confB");
    fetch(32'h0000_0004, 1'b1, 2, "confA2");
    fetch(32'h0000_0044, 1'b1, 0, "confB2");

    fetch(32'h0000_0008, 1'b1, 0, "prime8");
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h0000_0100; iwait = 1'b1;
    @(negedge CLK);
    chk("redir_miss", {31'd0, ihit}, 32'd0);
    @(posedge CLK); #1;
    imemaddr = 32'h0000_0008;
    exp_q.push_back(mem_of(32'h0000_0008));
    @(negedge CLK);
    chk("redir_fill_nohit", {31'd0, ihit}, 32'd0);
    chk("redir_fill_iaddr", iaddr, 32'h0000_0100);
    @(posedge CLK); #1;
    iwait = 1'b0; iload = mem_of(32'h0000_0100);
    @(negedge CLK);
    chk("redir_done_iren", {31'd0, iREN}, 32'd1);
    chk("redir_done_iaddr", iaddr, 32'h0000_0100);
    chk("redir_done_nohit", {31'd0, ihit}, 32'd0);
    @(posedge CLK); #1;
    iwait = 1'b1;
    @(negedge CLK);
    chk("redir_idle_hit", {31'd0, ihit}, 32'd1);
    pop_chk("redir8");
    @(posedge CLK); #1;
    imemREN = 1'b0;
    fetch(32'h0000_0100, 1'b0, 0, "redir_100_hit");

    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h0000_0040; iwait = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstfill_iren_before", {31'd0, iREN}, 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk("rstfill_iren_async", {31'd0, iREN}, 32'd0);
    chk("rstfill_iaddr", iaddr, 32'd0);
    chk("rstfill_ihit", {31'd0, ihit}, 32'd0);
    #1 nRST = 1'b1;
    imemREN = 1'b0;
    fetch(32'h0000_0000, 1'b1, 0, "post_rst0");
    fetch(32'h0000_0100, 1'b1, 1, "post_rst100");

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
